// File: rtl/mips_mem_responder_if.sv
// Bus bundle between the MIPS core side (master) and the memory responder (slave).
// Carries the fetch port, the data port, the byte-serial loader handshake and fault reporting.
interface mips_mem_responder_if;
   logic [31:0] instr_addr;
   logic [31:0] instr_data;
   logic        data_rd_wr;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_done;
   logic        busy;
   logic        fault;
   logic [31:0] fault_addr;

   modport master (
      output instr_addr, data_rd_wr, data_addr, data_wdata,
             ld_start, ld_valid, ld_byte, ld_last,
      input  instr_data, data_rdata, ld_ready, ld_done, busy, fault, fault_addr
   );

   modport slave (
      input  instr_addr, data_rd_wr, data_addr, data_wdata,
             ld_start, ld_valid, ld_byte, ld_last,
      output instr_data, data_rdata, ld_ready, ld_done, busy, fault, fault_addr
   );
endinterface

// File: rtl/mips_mem_responder.sv
// Word-organised RAM serving the MIPS fetch and data ports, with a byte-serial
// program loader that fills the RAM while the core is held in reset.
module mips_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_mem_responder_if.slave   bus
);
   localparam int unsigned     AW          = $clog2(DEPTH_WORDS);
   localparam logic [29:0]     LP_DEPTH    = 30'(DEPTH_WORDS);
   localparam logic [AW-1:0]   LP_LAST_PTR = AW'(DEPTH_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE} state_t;

   state_t          r_state, w_state_n;
   logic [AW-1:0]   r_ptr, w_ptr_n;
   logic [1:0]      r_lane, w_lane_n;
   logic [31:0]     r_asm, w_asm_n;
   logic            r_last, w_last_n;
   logic            w_ld_we;

   logic [31:0]     r_mem [DEPTH_WORDS];
   logic [31:0]     r_instr_data, r_data_rdata, r_fault_addr;
   logic            r_fault;

   logic [31:0]     w_i_off, w_d_off;
   logic            w_i_ok, w_d_ok;
   logic [AW-1:0]   w_i_idx, w_d_idx;
   logic            w_busy, w_core_we;

   assign w_i_off   = bus.instr_addr - BASE_ADDR;
   assign w_d_off   = bus.data_addr  - BASE_ADDR;
   assign w_i_ok    = (w_i_off[1:0] == 2'b00) && (w_i_off[31:2] < LP_DEPTH);
   assign w_d_ok    = (w_d_off[1:0] == 2'b00) && (w_d_off[31:2] < LP_DEPTH);
   assign w_i_idx   = w_i_off[AW+1:2];
   assign w_d_idx   = w_d_off[AW+1:2];
   assign w_busy    = (r_state == S_LOAD) || (r_state == S_COMMIT);
   assign w_core_we = !bus.data_rd_wr && w_d_ok && !w_busy;

   assign bus.instr_data = r_instr_data;
   assign bus.data_rdata = r_data_rdata;
   assign bus.ld_ready   = (r_state == S_LOAD);
   assign bus.ld_done    = (r_state == S_DONE);
   assign bus.busy       = w_busy;
   assign bus.fault      = r_fault;
   assign bus.fault_addr = r_fault_addr;

   // RAM is never cleared; reset only suppresses writes in its own cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_ld_we)
            r_mem[r_ptr] <= r_asm;
         else if (w_core_we)
            r_mem[w_d_idx] <= bus.data_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr_data <= '0;
         r_data_rdata <= '0;
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end else begin
         r_instr_data <= w_i_ok ? r_mem[w_i_idx] : '0;
         r_data_rdata <= w_d_ok ? r_mem[w_d_idx] : '0;
         if (!r_fault) begin
            if (!w_d_ok) begin
               r_fault      <= 1'b1;
               r_fault_addr <= bus.data_addr;
            end else if (!w_i_ok) begin
               r_fault      <= 1'b1;
               r_fault_addr <= bus.instr_addr;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_lane  <= '0;
         r_asm   <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_ptr   <= w_ptr_n;
         r_lane  <= w_lane_n;
         r_asm   <= w_asm_n;
         r_last  <= w_last_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_ptr_n   = r_ptr;
      w_lane_n  = r_lane;
      w_asm_n   = r_asm;
      w_last_n  = r_last;
      w_ld_we   = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (bus.ld_valid) begin
               w_asm_n[{r_lane, 3'b000} +: 8] = bus.ld_byte;
               w_lane_n = r_lane + 2'd1;
               if (r_lane == 2'd3 || bus.ld_last) begin
                  w_state_n = S_COMMIT;
                  w_last_n  = bus.ld_last;
               end
            end
         end
         S_COMMIT: begin
            w_ld_we  = 1'b1;
            w_ptr_n  = r_ptr + 1'b1;
            w_lane_n = '0;
            w_asm_n  = '0;
            w_last_n = 1'b0;
            w_state_n = (r_last || r_ptr == LP_LAST_PTR) ? S_DONE : S_LOAD;
         end
         default: ;
      endcase
      // Restart overrides the next-state above, but the COMMIT write (w_ld_we) still lands.
      if (bus.ld_start) begin
         w_state_n = S_LOAD;
         w_ptr_n   = '0;
         w_lane_n  = '0;
         w_asm_n   = '0;
         w_last_n  = 1'b0;
      end
   end
endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: loader, fetch/data ports, faults, priority.
module tb_mips_mem_responder;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [7:0] img [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

   always #5 clk = ~clk;

   mips_mem_responder_if bus();

   mips_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      bus.ld_byte  = b;
      bus.ld_last  = last;
      bus.ld_valid = 1'b1;
      tick();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      bus.instr_addr = BASE;
      bus.data_rd_wr = 1'b1;
      bus.data_addr  = BASE;
      bus.data_wdata = '0;
      bus.ld_start   = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.ld_byte    = '0;
      bus.ld_last    = 1'b0;
      tick();
      tick();
      chk("rst_instr_data", bus.instr_data, 32'h0);
      chk("rst_data_rdata", bus.data_rdata, 32'h0);
      chk("rst_ld_ready",   32'(bus.ld_ready), 32'h0);
      chk("rst_ld_done",    32'(bus.ld_done),  32'h0);
      chk("rst_busy",       32'(bus.busy),     32'h0);
      chk("rst_fault",      32'(bus.fault),    32'h0);
      chk("rst_fault_addr", bus.fault_addr,    32'h0);
      reset = 1'b0;

      // Full two-word load, ld_valid held high throughout
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      chk("load_ready", 32'(bus.ld_ready), 32'h1);
      chk("load_busy",  32'(bus.busy),     32'h1);
      for (int i = 0; i < 8; i++) begin
         send(img[i], i == 7);
         if (i % 4 == 3) begin
            chk("commit_ready_low", 32'(bus.ld_ready), 32'h0);
            tick();
         end
      end
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      chk("load_done", 32'(bus.ld_done), 32'h1);
      chk("load_busy_clear", 32'(bus.busy), 32'h0);
      chk("load_ready_done", 32'(bus.ld_ready), 32'h0);

      // Fetch and data read of loaded image
      bus.instr_addr = BASE + 32'd4;
      bus.data_addr  = BASE;
      tick();
      chk("fetch_w1", bus.instr_data, 32'hDEADBEEF);
      chk("read_w0",  bus.data_rdata, 32'h12345678);

      // Repeated write with read-before-write and same-word fetch collision
      bus.data_addr  = BASE + 32'd8;
      bus.data_rd_wr = 1'b0;
      bus.data_wdata = 32'h1111_2222;
      tick();
      bus.data_wdata = 32'h0000_CAFE;
      bus.instr_addr = BASE + 32'd8;
      tick();
      chk("wr1_old_rdata", bus.data_rdata, 32'h11112222);
      chk("collision_old", bus.instr_data, 32'h11112222);
      tick();
      chk("wr2_rdata", bus.data_rdata, 32'h0000CAFE);
      tick();
      chk("wr3_rdata", bus.data_rdata, 32'h0000CAFE);
      bus.data_rd_wr = 1'b1;
      tick();
      chk("rd_after_wr", bus.data_rdata, 32'h0000CAFE);
      chk("fetch_after_wr", bus.instr_data, 32'h0000CAFE);
      chk("no_fault_yet", 32'(bus.fault), 32'h0);

      // Misaligned fetch
      bus.instr_addr = BASE + 32'd2;
      tick();
      chk("bad_fetch_data", bus.instr_data, 32'h0);
      chk("bad_fetch_fault", 32'(bus.fault), 32'h1);
      chk("bad_fetch_faddr", bus.fault_addr, BASE + 32'd2);
      bus.instr_addr = BASE + 32'd8;
      bus.data_addr  = BASE + 32'd3;
      tick();
      chk("fault_sticky_addr", bus.fault_addr, BASE + 32'd2);
      chk("bad_read_data", bus.data_rdata, 32'h0);
      bus.data_addr = BASE;
      pulse_reset();
      chk("fault_cleared", 32'(bus.fault), 32'h0);
      chk("faddr_cleared", bus.fault_addr, 32'h0);

      // Both ports fault together: data address wins (below BASE wraps)
      bus.instr_addr = BASE + 32'd1;
      bus.data_addr  = BASE - 32'd4;
      tick();
      chk("dual_fault", 32'(bus.fault), 32'h1);
      chk("dual_faddr", bus.fault_addr, BASE - 32'd4);
      bus.instr_addr = BASE + 32'd8;
      bus.data_addr  = BASE;
      pulse_reset();

      // Out-of-range write is dropped
      bus.data_addr  = BASE + 32'd64;
      bus.data_rd_wr = 1'b0;
      bus.data_wdata = 32'h5555_5555;
      tick();
      chk("oor_fault", 32'(bus.fault), 32'h1);
      chk("oor_faddr", bus.fault_addr, BASE + 32'd64);
      chk("oor_rdata", bus.data_rdata, 32'h0);
      bus.data_rd_wr = 1'b1;
      bus.data_addr  = BASE;
      tick();
      chk("oor_ram_intact", bus.data_rdata, 32'h12345678);
      pulse_reset();

      // Partial final word
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b1);
      chk("partial_commit_busy",  32'(bus.busy),     32'h1);
      chk("partial_commit_ready", 32'(bus.ld_ready), 32'h0);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      tick();
      chk("partial_done", 32'(bus.ld_done), 32'h1);
      tick();
      chk("partial_word0", bus.data_rdata, 32'h00CCBBAA);

      // Restart mid-word; core write during busy is dropped silently
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start   = 1'b0;
      bus.data_addr  = BASE + 32'd4;
      bus.data_rd_wr = 1'b0;
      bus.data_wdata = 32'h9999_9999;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      bus.ld_valid = 1'b0;
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start   = 1'b0;
      bus.data_rd_wr = 1'b1;
      chk("restart_ready", 32'(bus.ld_ready), 32'h1);
      send(8'h33, 1'b1);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      tick();
      chk("restart_done", 32'(bus.ld_done), 32'h1);
      bus.data_addr = BASE;
      tick();
      chk("restart_word0", bus.data_rdata, 32'h00000033);
      bus.data_addr = BASE + 32'd4;
      tick();
      chk("busy_write_dropped", bus.data_rdata, 32'hDEADBEEF);
      chk("busy_write_nofault", 32'(bus.fault), 32'h0);

      // Reset in the middle of LOAD
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
      send(8'h77, 1'b0);
      bus.ld_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("midrst_ready", 32'(bus.ld_ready), 32'h0);
      chk("midrst_busy",  32'(bus.busy),     32'h0);
      chk("midrst_done",  32'(bus.ld_done),  32'h0);
      reset = 1'b0;
      bus.data_addr = BASE;
      tick();
      chk("midrst_word0", bus.data_rdata, 32'h00000033);
      bus.data_addr = BASE + 32'd4;
      tick();
      chk("midrst_word1", bus.data_rdata, 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the MIPS core's instruction and data interfaces. It holds a single word-organised RAM image. The RAM serves two ports: a read-only instruction fetch port, and a read/write data port driven by the core's data_rd_wr / data_addr / data_out signals. It also contains a byte-serial program loader with a valid/ready handshake, which fills the RAM while the core is held in reset. It sits beside the mips core at top level and replaces the bench-only memory models.

Parameters:
BASE_ADDR  32'h0000_0000  byte address mapped to word 0; must be 4-byte aligned
DEPTH_WORDS  1024  number of 32-bit words; power of two, 4..65536

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
instr_addr  in  32  fetch byte address from the core
instr_data  out  32  fetched word, registered
data_rd_wr  in  1  1 = read, 0 = write
data_addr  in  32  data byte address from the core
data_wdata  in  32  store data (core data_out)
data_rdata  out  32  load data, registered (core data_in)
ld_start  in  1  single-cycle pulse; begin loading at word 0
ld_valid  in  1  ld_byte is valid
ld_byte  in  8  image byte, little-endian within each word
ld_last  in  1  qualifies the final byte of the image
ld_ready  out  1  loader accepts a byte this cycle
ld_done  out  1  image committed; held until the next ld_start or reset
busy  out  1  loader active (LOAD or COMMIT state)
fault  out  1  sticky access-error flag
fault_addr  out  32  address of the first faulting access

Behaviour:
- Reset (synchronous):
  - Outputs: instr_data=0, data_rdata=0, ld_ready=0, ld_done=0, busy=0, fault=0, fault_addr=0.
  - Loader goes to IDLE; the byte assembler and word pointer clear.
  - RAM contents are NOT cleared.
  - Reset wins over every other input in the same cycle.
- Address map:
  - off = addr - BASE_ADDR (32-bit, wraps modulo 2^32).
  - A port is valid when off[1:0]==0 and off[31:2] < DEPTH_WORDS; index = off[31:2].
- Instruction port:
  - Every cycle, instr_data <= mem[index] on the following clock edge (1-cycle latency).
  - Invalid address: instr_data <= 0 and a fault is raised.
- Data read (data_rd_wr=1):
  - data_rdata <= mem[index] next edge.
  - Invalid address: data_rdata <= 0 and a fault is raised.
- Data write (data_rd_wr=0):
  - mem[index] <= data_wdata at the edge; data_rdata <= old mem[index] (read-before-write).
  - The core holds data_rd_wr low across several cycles, so repeated identical writes must be harmless.
  - Invalid address: the write is dropped and a fault is raised.
- Same-word collision (instr port reads the word the data port writes in the same cycle): instr_data returns the OLD word.
- Loader FSM, states IDLE, LOAD, COMMIT, DONE:
  - IDLE: ld_ready=0. ld_start -> LOAD with ptr=0, lane=0, assembler=0.
  - LOAD: ld_ready=1. On ld_valid & ld_ready, ld_byte goes into assembler[8*lane +: 8] and lane increments.
  - LOAD exit to COMMIT: when lane was 3, or ld_last=1.
  - COMMIT (exactly one cycle, ld_ready=0):
    - Write the assembler to mem[ptr]; unfilled upper lanes are 0.
    - Then ptr+1, lane=0, assembler=0.
    - Go to DONE if the committed byte had ld_last=1 or ptr was DEPTH_WORDS-1; otherwise back to LOAD.
  - DONE: ld_done=1 and ld_ready=0; ld_start -> LOAD.
  - ld_start in LOAD or COMMIT: restart at ptr=0 and drop the partial word. The restart takes effect after any COMMIT write already in that cycle.
  - ld_valid while ld_ready=0: ignored; no byte is consumed.
- Loader vs core:
  - While busy=1, core data writes are dropped without a fault; reads are still served.
  - The loader's RAM write has priority over all other writes.
- Fault capture:
  - fault sets on the first invalid access from either port.
  - fault_addr captures that address. When both ports fault in the same cycle, the data port address is recorded.
  - Later faults do not update fault_addr. Only reset clears fault and fault_addr.
- Throughput: one fetch and one data access per cycle, both with a fixed 1-cycle read latency and no stalls. The core's 5-stage sequencer presents each address at least one cycle before it samples the result.

Test Plan:
- Load: reset, ld_start, then stream bytes 78 56 34 12 EF BE AD DE with ld_last on DE, ld_valid held high -> mem[0]=12345678, mem[1]=DEADBEEF; ld_ready drops for the one COMMIT cycle after each 4th byte; ld_done=1 thereafter.
- Fetch: instr_addr=BASE_ADDR+4 after the load above -> instr_data=DEADBEEF one cycle later; instr_addr=BASE_ADDR+2 -> instr_data=0, fault=1, fault_addr=BASE_ADDR+2.
- Data: write 0000CAFE to BASE_ADDR+8 for 3 consecutive cycles, then read -> data_rdata=0000CAFE; during the first write cycle data_rdata shows the old word. Same-cycle fetch of +8 returns the old word.
- Partial/restart: send 3 bytes AA BB CC with ld_last on CC -> word 0 = 00CCBBAA. Send 2 bytes then ld_start -> ptr restarts at 0 and the partial bytes are never written.
- Range/priority: data write to BASE_ADDR+4*DEPTH_WORDS -> RAM unchanged, fault=1. A core write during busy is dropped with no fault. Reset mid-LOAD -> IDLE, ld_ready=0, earlier committed words preserved.
